// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed-latency req/ready handshake.
// It also watches for a signature store that reports a pass/fail verdict.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int SIG_ADDR    = 100,
    parameter int SIG_VALUE   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        done,
    output logic        pass,
    output logic        err
);

    localparam int          LP_AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LP_BYTES     = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] LP_SIG_ADDR  = 32'(SIG_ADDR);
    localparam logic [31:0] LP_SIG_VALUE = 32'(SIG_VALUE);
    localparam logic [3:0]  LP_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        LP_NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_next_cnt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_enter_resp;
    logic             w_cur_we;
    logic [31:0]      w_cur_addr;
    logic [31:0]      w_cur_wdata;
    logic             w_legal;
    logic [LP_AW-1:0] w_idx;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next_state = LP_NO_WAIT ? ST_RESP : ST_WAIT;
                    w_next_cnt   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_next_state = ST_RESP;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_wait_cnt + 4'd1;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // With no wait states the response edge is the acceptance edge, so use the live inputs.
    assign w_enter_resp = (w_next_state == ST_RESP);
    assign w_cur_we     = (r_state == ST_IDLE) ? we    : r_we;
    assign w_cur_addr   = (r_state == ST_IDLE) ? addr  : r_addr;
    assign w_cur_wdata  = (r_state == ST_IDLE) ? wdata : r_wdata;
    assign w_legal      = (w_cur_addr[1:0] == 2'b00) && (w_cur_addr < LP_BYTES);
    assign w_idx        = w_cur_addr[LP_AW+1:2];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            if (r_state == ST_IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'd0;
            done  <= 1'b0;
            pass  <= 1'b0;
            err   <= 1'b0;
        end else if (w_enter_resp) begin
            if (!w_legal) begin
                err <= 1'b1;
                if (!w_cur_we) begin
                    rdata <= 32'd0;
                end
            end else if (w_cur_we) begin
                // Only the first legal signature store decides the verdict.
                if (w_cur_addr == LP_SIG_ADDR && !done) begin
                    done <= 1'b1;
                    pass <= (w_cur_wdata == LP_SIG_VALUE) && !err;
                end
            end else begin
                rdata <= r_mem[w_idx];
            end
        end
    end

    // NOTE: the memory array has no reset; contents survive reset and map to plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_legal && w_cur_we) begin
            r_mem[w_idx] <= w_cur_wdata;
        end
    end

    assign ready = (r_state == ST_RESP);

endmodule
